// File: rtl/rf_access_ctrl.sv
// rf_access_ctrl: initiator-side controller for the register bank.
// Accepts one register-op command per valid/ready handshake. It reads both source operands
// through the bank read ports, computes the result and writes it back through the bank write
// port. CLR issues a bank clear instead of a write. Each op takes IDLE -> READ -> EXEC -> WB.
//
// Ports
//   clk, reset              rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready     command handshake; ready only in IDLE
//   cmd_op/rd/rs1/rs2/imm   opcode, destination, sources, immediate
//   rf_raddr_a/b            bank read addresses (registered on accept)
//   rf_rdata_a/b            bank read data (combinational in the bank)
//   rf_we/waddr/wdata       bank write port; rf_we is a 1-cycle pulse in WB
//   rf_clear                bank clear, 1-cycle pulse in WB for CLR
//   done                    1-cycle pulse in WB
//   result                  last computed result
//   flag_z/n/c              status flags (only with STATUS_FLAGS_EN)
//
// Optional feature: define STATUS_FLAGS_EN to add the zero/negative/carry flag outputs.
module rf_access_ctrl #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic [ADDR_W-1:0] cmd_rs1,
    input  logic [ADDR_W-1:0] cmd_rs2,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [ADDR_W-1:0] rf_raddr_a,
    output logic [ADDR_W-1:0] rf_raddr_b,
    input  logic [DATA_W-1:0] rf_rdata_a,
    input  logic [DATA_W-1:0] rf_rdata_b,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rf_clear,
    output logic              done,
    output logic [DATA_W-1:0] result
`ifdef STATUS_FLAGS_EN
    ,
    output logic              flag_z,
    output logic              flag_n,
    output logic              flag_c
`endif
);

    localparam logic [2:0] OpMov = 3'd0;
    localparam logic [2:0] OpAdd = 3'd1;
    localparam logic [2:0] OpSub = 3'd2;
    localparam logic [2:0] OpAnd = 3'd3;
    localparam logic [2:0] OpOr  = 3'd4;
    localparam logic [2:0] OpXor = 3'd5;
    localparam logic [2:0] OpLdi = 3'd6;
    localparam logic [2:0] OpClr = 3'd7;

    typedef enum logic [1:0] {StIdle, StRead, StExec, StWb} state_e;

    state_e              state_q, state_d;
    logic [2:0]          op_q;
    logic [ADDR_W-1:0]   rd_q, raddr_a_q, raddr_b_q;
    logic [DATA_W-1:0]   imm_q, opa_q, opb_q, result_q;
    logic [DATA_W:0]     sum, diff;
    logic [DATA_W-1:0]   exec_res;
    logic                exec_c;
    logic                accept;

    assign accept = (state_q == StIdle) && cmd_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (cmd_valid) state_d = StRead;
            StRead:  state_d = StExec;
            StExec:  state_d = StWb;
            StWb:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Extra top bit of sum is the carry-out; of diff it is the borrow (rs1 < rs2 unsigned).
    always_comb begin
        sum      = {1'b0, opa_q} + {1'b0, opb_q};
        diff     = {1'b0, opa_q} - {1'b0, opb_q};
        exec_res = result_q;
        exec_c   = 1'b0;
        unique case (op_q)
            OpMov: exec_res = opa_q;
            OpAdd: begin
                exec_res = sum[DATA_W-1:0];
                exec_c   = sum[DATA_W];
            end
            OpSub: begin
                exec_res = diff[DATA_W-1:0];
                exec_c   = diff[DATA_W];
            end
            OpAnd: exec_res = opa_q & opb_q;
            OpOr:  exec_res = opa_q | opb_q;
            OpXor: exec_res = opa_q ^ opb_q;
            OpLdi: exec_res = imm_q;
            OpClr: exec_res = result_q;  // no write, result keeps its value
            default: exec_res = result_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= OpMov;
            rd_q      <= '0;
            imm_q     <= '0;
            raddr_a_q <= '0;
            raddr_b_q <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            result_q  <= '0;
        end else begin
            if (accept) begin
                op_q      <= cmd_op;
                rd_q      <= cmd_rd;
                imm_q     <= cmd_imm;
                raddr_a_q <= cmd_rs1;
                raddr_b_q <= cmd_rs2;
            end
            // Operands are snapshotted here, so rd==rs1 cannot disturb the read.
            if (state_q == StRead) begin
                opa_q <= rf_rdata_a;
                opb_q <= rf_rdata_b;
            end
            if (state_q == StExec) begin
                result_q <= exec_res;
            end
        end
    end

`ifdef STATUS_FLAGS_EN
    logic flag_z_q, flag_n_q, flag_c_q;

    // Loaded at the end of EXEC so the new flags are visible during WB.
    always_ff @(posedge clk) begin
        if (reset) begin
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else if (state_q == StExec) begin
            if (op_q == OpClr) begin
                flag_z_q <= 1'b0;
                flag_n_q <= 1'b0;
                flag_c_q <= 1'b0;
            end else begin
                flag_z_q <= (exec_res == '0);
                flag_n_q <= exec_res[DATA_W-1];
                flag_c_q <= exec_c;
            end
        end
    end

    assign flag_z = flag_z_q;
    assign flag_n = flag_n_q;
    assign flag_c = flag_c_q;
`else
    logic unused_carry;
    assign unused_carry = exec_c;
`endif

    assign cmd_ready  = (state_q == StIdle);
    assign rf_raddr_a = raddr_a_q;
    assign rf_raddr_b = raddr_b_q;
    assign rf_we      = (state_q == StWb) && (op_q != OpClr);
    assign rf_clear   = (state_q == StWb) && (op_q == OpClr);
    assign done       = (state_q == StWb);
    assign rf_waddr   = rd_q;
    assign rf_wdata   = result_q;
    assign result     = result_q;

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Testbench for rf_access_ctrl: a behavioural 16x16 bank driven by the DUT ports, a reference
// register file that predicts each op's result, and a scoreboard queue compared on done.
module tb_rf_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [3:0]  cmd_rd, cmd_rs1, cmd_rs2;
    logic [15:0] cmd_imm;
    logic [3:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
    logic [15:0] rf_rdata_a, rf_rdata_b, rf_wdata, result;
    logic        rf_we, rf_clear, done;
`ifdef STATUS_FLAGS_EN
    logic        flag_z, flag_n, flag_c;
`endif

    rf_access_ctrl #(.DATA_W(16), .ADDR_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_rd     (cmd_rd),
        .cmd_rs1    (cmd_rs1),
        .cmd_rs2    (cmd_rs2),
        .cmd_imm    (cmd_imm),
        .rf_raddr_a (rf_raddr_a),
        .rf_raddr_b (rf_raddr_b),
        .rf_rdata_a (rf_rdata_a),
        .rf_rdata_b (rf_rdata_b),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .rf_clear   (rf_clear),
        .done       (done),
        .result     (result)
`ifdef STATUS_FLAGS_EN
        ,
        .flag_z     (flag_z),
        .flag_n     (flag_n),
        .flag_c     (flag_c)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural bank, written only through the DUT write/clear ports.
    logic [15:0] bank [16];
    assign rf_rdata_a = bank[rf_raddr_a];
    assign rf_rdata_b = bank[rf_raddr_b];
    always @(posedge clk) begin
        if (rf_clear) begin
            for (int i = 0; i < 16; i++) bank[i] <= 16'h0;
        end else if (rf_we) begin
            bank[rf_waddr] <= rf_wdata;
        end
    end

    typedef struct {
        logic        clr;
        logic [3:0]  addr;
        logic [15:0] data;
        logic        z, n, c;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] ref_rf [16];
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Reference model: predicts the write-back and updates the reference register file.
    function automatic void push_exp(input logic [2:0] op, input logic [3:0] rd,
                                     input logic [3:0] rs1, input logic [3:0] rs2,
                                     input logic [15:0] imm);
        exp_t        e;
        logic [15:0] a, b, r;
        logic [16:0] wide;
        logic        c;
        a = ref_rf[rs1];
        b = ref_rf[rs2];
        c = 1'b0;
        r = 16'h0;
        case (op)
            3'd0: r = a;
            3'd1: begin
                wide = {1'b0, a} + {1'b0, b};
                r    = wide[15:0];
                c    = wide[16];
            end
            3'd2: begin
                r = a - b;
                c = (a < b);
            end
            3'd3: r = a & b;
            3'd4: r = a | b;
            3'd5: r = a ^ b;
            3'd6: r = imm;
            default: r = 16'h0;
        endcase
        e.clr  = (op == 3'd7);
        e.addr = rd;
        e.data = r;
        e.z    = e.clr ? 1'b0 : (r == 16'h0);
        e.n    = e.clr ? 1'b0 : r[15];
        e.c    = e.clr ? 1'b0 : c;
        if (e.clr) begin
            for (int i = 0; i < 16; i++) ref_rf[i] = 16'h0;
        end else begin
            ref_rf[rd] = r;
        end
        sb.push_back(e);
    endfunction

    // Scoreboard checker: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if ((rf_we || rf_clear) && !done) chk("we_without_done", 1, 0);
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("sb_clear", rf_clear, e.clr);
                chk("sb_we", rf_we, !e.clr);
                if (!e.clr) begin
                    chk("sb_waddr", rf_waddr, e.addr);
                    chk("sb_wdata", rf_wdata, e.data);
                    chk("sb_result", result, e.data);
                end
`ifdef STATUS_FLAGS_EN
                chk("sb_flag_z", flag_z, e.z);
                chk("sb_flag_n", flag_n, e.n);
                chk("sb_flag_c", flag_c, e.c);
`endif
            end
        end
    end

    // One op with the cycle-by-cycle handshake/latency checks.
    task automatic run_op(input logic [2:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                          input logic [3:0] rs2, input logic [15:0] imm);
        @(negedge clk);
        chk("idle_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_rd    = rd;
        cmd_rs1   = rs1;
        cmd_rs2   = rs2;
        cmd_imm   = imm;
        push_exp(op, rd, rs1, rs2, imm);
        @(negedge clk);  // READ
        cmd_valid = 1'b0;
        chk("read_ready", cmd_ready, 0);
        chk("read_raddr_a", rf_raddr_a, rs1);
        chk("read_raddr_b", rf_raddr_b, rs2);
        chk("read_done", done, 0);
        @(negedge clk);  // EXEC
        chk("exec_ready", cmd_ready, 0);
        chk("exec_done", done, 0);
        @(negedge clk);  // WB
        chk("wb_done", done, 1);
        chk("wb_ready", cmd_ready, 0);
        @(negedge clk);  // back in IDLE
        chk("ret_ready", cmd_ready, 1);
        chk("ret_done", done, 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            bank[i]   = 16'h0;
            ref_rf[i] = 16'h0;
        end
        reset     = 1'b1;
        cmd_valid = 1'b1;  // command during reset must be ignored
        cmd_op    = 3'd6;
        cmd_rd    = 4'd9;
        cmd_rs1   = 4'd0;
        cmd_rs2   = 4'd0;
        cmd_imm   = 16'hdead;
        repeat (3) @(negedge clk);
        chk("rst_done", done, 0);
        chk("rst_we", rf_we, 0);
        chk("rst_clear", rf_clear, 0);
        chk("rst_result", result, 0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_raddr_a", rf_raddr_a, 0);
        reset     = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", cmd_ready, 1);
        repeat (4) @(negedge clk);

        // LDI r3 = 0x1234 with full latency checks.
        run_op(3'd6, 4'd3, 4'd0, 4'd0, 16'h1234);

        // Two-cycle reset while idle.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_result", result, 0);
        chk("midrst_waddr", rf_waddr, 0);
        chk("midrst_we", rf_we, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_ready", cmd_ready, 1);
        chk("midrst_done", done, 0);

        // ADD wrapping to zero with carry out.
        run_op(3'd6, 4'd1, 4'd0, 4'd0, 16'hffff);
        run_op(3'd6, 4'd2, 4'd0, 4'd0, 16'h0001);
        run_op(3'd1, 4'd5, 4'd1, 4'd2, 16'h0);

        // SUB with borrow.
        run_op(3'd6, 4'd1, 4'd0, 4'd0, 16'h0001);
        run_op(3'd6, 4'd2, 4'd0, 4'd0, 16'h0002);
        run_op(3'd2, 4'd4, 4'd1, 4'd2, 16'h0);

        // Remaining ops, plus rs1==rs2 and rd==rs1.
        run_op(3'd6, 4'd6, 4'd0, 4'd0, 16'hf0f0);
        run_op(3'd6, 4'd7, 4'd0, 4'd0, 16'h3c3c);
        run_op(3'd0, 4'd8, 4'd6, 4'd0, 16'h0);
        run_op(3'd3, 4'd9, 4'd6, 4'd7, 16'h0);
        run_op(3'd4, 4'd10, 4'd6, 4'd7, 16'h0);
        run_op(3'd5, 4'd11, 4'd6, 4'd7, 16'h0);
        run_op(3'd1, 4'd6, 4'd6, 4'd6, 16'h0);

        // cmd_valid held high across two commands.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = 3'd5; cmd_rd = 4'd12; cmd_rs1 = 4'd3; cmd_rs2 = 4'd7; cmd_imm = 16'h0;
        push_exp(3'd5, 4'd12, 4'd3, 4'd7, 16'h0);
        @(negedge clk);
        cmd_op = 3'd4; cmd_rd = 4'd13; cmd_rs1 = 4'd12; cmd_rs2 = 4'd5;
        chk("b2b_ready_e1", cmd_ready, 0);
        @(negedge clk);
        chk("b2b_ready_e2", cmd_ready, 0);
        @(negedge clk);
        chk("b2b_ready_e3", cmd_ready, 0);
        chk("b2b_done_1", done, 1);
        @(negedge clk);
        chk("b2b_ready_e4", cmd_ready, 1);
        push_exp(3'd4, 4'd13, 4'd12, 4'd5, 16'h0);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("b2b2_ready", cmd_ready, 0);
        chk("b2b2_raddr_a", rf_raddr_a, 4'd12);
        @(negedge clk);
        @(negedge clk);
        chk("b2b_done_2", done, 1);
        @(negedge clk);
        chk("b2b2_ret_ready", cmd_ready, 1);

        // Reset during EXEC drops the ADD.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = 3'd1; cmd_rd = 4'd14; cmd_rs1 = 4'd1; cmd_rs2 = 4'd2; cmd_imm = 16'h0;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_done", done, 0);
        chk("abort_we", rf_we, 0);
        chk("abort_ready", cmd_ready, 1);
        chk("abort_result", result, 0);
        @(negedge clk);
        chk("abort_done2", done, 0);
        chk("abort_ready2", cmd_ready, 1);

        // CLR, then confirm the bank really cleared.
        run_op(3'd7, 4'd0, 4'd0, 4'd0, 16'h0);
        run_op(3'd0, 4'd15, 4'd3, 4'd0, 16'h0);

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
